serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//   Controller that sequences an external 1-bit full adder to perform a
//   WIDTH-bit bit-serial addition, LSB first. Latches operands on a start
//   pulse, drives the adder's a/b/cin inputs one bit per clock, collects
//   sum bits and carry, and reports the result with a busy/done handshake.
//   Sits between a requester and the combinational full-adder cell.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2); bit counter is $clog2(WIDTH+1) bits
// PORTS
//   clk      in   1      clock; all state changes on rising edge
//   resetb   in   1      synchronous reset, active-low
//   start    in   1      request; sampled only in IDLE
//   a_in     in   WIDTH  operand A, latched when start accepted
//   b_in     in   WIDTH  operand B, latched when start accepted
//   cin_in   in   1      carry-in, latched when start accepted
//   fa_a     out  1      to full adder: current A bit
//   fa_b     out  1      to full adder: current B bit
//   fa_cin   out  1      to full adder: running carry
//   fa_s     in   1      from full adder: sum bit (combinational of fa_*)
//   fa_co    in   1      from full adder: carry-out
//   busy     out  1      high while in RUN
//   done     out  1      one-cycle pulse, result valid
//   sum_out  out  WIDTH  result; held stable from done until next accepted start
//   cout_out out  1      final carry-out; held like sum_out
// BEHAVIOUR
//   Reset (resetb==0 at a rising edge): state=IDLE, busy=0, done=0,
//     sum_out=0, cout_out=0, fa_a/fa_b/fa_cin=0, operand/carry regs=0,
//     counter=0. Reset mid-RUN or in DONE aborts; no done pulse is produced.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start==1 at edge E0 -> latch a_in,b_in into shift regs, carry<=cin_in,
//     counter<=0, clear sum_out and cout_out, go RUN. start==0 -> stay.
//   RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry (registered sources,
//     no comb path from start). Each edge: sum shift reg shifts right with
//     fa_s entering MSB; carry<=fa_co; a_sh/b_sh shift right; counter+1.
//     After WIDTH RUN edges (edge E_WIDTH): sum_out=full result,
//     cout_out=last fa_co, go DONE.
//   DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE.
//   Latency: done high in the cycle following edge E_WIDTH; busy high for
//     exactly WIDTH cycles. Min start-to-start period WIDTH+2 cycles.
//   start in RUN or DONE ignored (not queued); operand inputs may change
//     freely after E0 without effect.
//   fa_a/fa_b/fa_cin are 0 outside RUN.
//   Result equals (a_in + b_in + cin_in) mod 2^WIDTH; cout_out = bit WIDTH.
//   start held high continuously: new op accepted at each IDLE edge,
//     i.e. one done pulse every WIDTH+2 cycles.
// TESTING (WIDTH=8; bench models full adder: fa_s=a^b^cin, fa_co=maj)
//   1. a=8'h03,b=8'h05,cin=0, start 1 cycle -> busy 8 cycles, done 1 cycle,
//      sum_out=8'h08, cout_out=0.
//   2. a=8'hFF,b=8'h01,cin=0 -> sum_out=8'h00, cout_out=1 (full carry ripple).
//   3. a=8'hA5,b=8'h5A,cin=1 -> sum_out=8'h00, cout_out=1; check fa_cin=1 on
//      first RUN cycle.
//   4. start pulsed and a_in/b_in changed during RUN -> ignored; result of
//      first op unchanged, single done pulse.
//   5. resetb=0 on 4th RUN cycle -> next cycle busy=0, done=0, sum_out=0;
//      no done; new start after release gives correct result.
//   6. start held high, ops a=1,b=1 -> done every 10 cycles, sum_out=8'h02,
//      sum_out stable between pulses except cleared at each accept edge.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences an external 1-bit full adder
// LSB first over WIDTH clocks and returns the sum with a busy/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  // Adder inputs come only from registers and are forced low outside RUN.
  assign fa_a   = busy & a_sh[0];
  assign fa_b   = busy & b_sh[0];
  assign fa_cin = busy & carry;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            s_sh     <= '0;
            carry    <= cin_in;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum_out  <= {fa_s, s_sh[WIDTH-1:1]};
            cout_out <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
